breath_sequencer: RTL and testbench



---
 rtl/breath_pkg.sv | 19 +
 rtl/breath_sequencer_if.sv | 19 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/breath_sequencer.sv | 131 +++++++++++++
 tb/tb_breath_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/breath_pkg.sv
// Shared types and timing helpers for the breathing LED sequencer.
package breath_pkg;

  typedef enum logic [1:0] {SPD_2S, SPD_1S, SPD_500MS, SPD_250MS} speed_e;

  typedef enum logic {RISE, FALL} breath_state_e;

  localparam int unsigned PERIOD_MS [4] = '{2000, 1000, 500, 250};

  // Clocks per brightness step: half a breath split over MAX_BRIGHT steps.
  function automatic int unsigned step_clk(input logic [1:0] mode,
                                           input int unsigned clk_freq,
                                           input int unsigned max_bright);
    longint unsigned v;
    v = 64'(PERIOD_MS[mode]) * 64'(clk_freq / 1000) / 64'(2 * max_bright);
    return 32'(v);
  endfunction

endpackage

// File: rtl/breath_sequencer_if.sv
// Button inputs and ramp/colour/speed outputs of the breathing sequencer.
interface breath_sequencer_if;
  logic [1:0] btn;
  logic [1:0] speed_mode;
  logic [3:0] led_mode;
  logic [7:0] brightness;
  logic [2:0] color_idx;
  logic       cycle_done;

  modport master (
    input  btn,
    output speed_mode, led_mode, brightness, color_idx, cycle_done
  );

  modport slave (
    output btn,
    input  speed_mode, led_mode, brightness, color_idx, cycle_done
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, ms-sampled debounce and a one-clk pulse on a 0->1 stable change.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] run_q;
  logic             press_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      run_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      press_q <= 1'b0;
      if (ms_tick) begin
        if (sync_q[1] != stable_q) begin
          // The DEBOUNCE_MS-th consecutive differing sample commits the new level.
          if (run_q == CNT_W'(DEBOUNCE_MS - 1)) begin
            stable_q <= sync_q[1];
            run_q    <= '0;
            press_q  <= sync_q[1];
          end else begin
            run_q <= run_q + 1'b1;
          end
        end else begin
          run_q <= '0;
        end
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/breath_sequencer.sv
// Speed selection, triangular brightness ramp and colour stepping for the breathing LED.
module breath_sequencer
  import breath_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 125_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned MAX_BRIGHT  = 100,
  parameter int unsigned NUM_COLORS  = 7
) (
  input logic              clk,
  input logic              rst,
  breath_sequencer_if.master bus
);

  localparam int unsigned MS_DIV = CLK_FREQ / 1000;
  localparam int unsigned MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int unsigned STEP_0 = step_clk(2'd0, CLK_FREQ, MAX_BRIGHT);
  localparam int unsigned STEP_1 = step_clk(2'd1, CLK_FREQ, MAX_BRIGHT);
  localparam int unsigned STEP_2 = step_clk(2'd2, CLK_FREQ, MAX_BRIGHT);
  localparam int unsigned STEP_3 = step_clk(2'd3, CLK_FREQ, MAX_BRIGHT);
  localparam int unsigned STEP_W = (STEP_0 > 1) ? $clog2(STEP_0) : 1;
  localparam logic [7:0]  MAX_B  = 8'(MAX_BRIGHT);
  localparam logic [2:0]  LAST_C = 3'(NUM_COLORS - 1);

  if (STEP_3 < 1) begin : g_step_bad
    $error("breath_sequencer: step interval below one clock");
  end

  logic [MS_W-1:0]   ms_cnt_q;
  logic              ms_tick;
  logic              up_press, down_press;
  speed_e            speed_q, speed_d;
  logic              speed_chg;
  logic [STEP_W-1:0] step_cnt_q, step_last;
  logic              step_tick;
  breath_state_e     state_q;
  logic [7:0]        bright_q;
  logic [2:0]        color_q;
  logic              cycle_done_q;

  assign ms_tick = (ms_cnt_q == MS_W'(MS_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ms_cnt_q <= '0;
    else     ms_cnt_q <= ms_tick ? '0 : ms_cnt_q + 1'b1;
  end

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick),
    .btn     (bus.btn[0]),
    .press   (up_press)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_down (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick),
    .btn     (bus.btn[1]),
    .press   (down_press)
  );

  always_comb begin
    speed_d = speed_q;
    if (up_press && !down_press && speed_q != SPD_250MS) begin
      speed_d = speed_e'(speed_q + 2'd1);
    end else if (down_press && !up_press && speed_q != SPD_2S) begin
      speed_d = speed_e'(speed_q - 2'd1);
    end
  end

  assign speed_chg = (speed_d != speed_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) speed_q <= SPD_2S;
    else     speed_q <= speed_d;
  end

  always_comb begin
    unique case (speed_q)
      SPD_2S:    step_last = STEP_W'(STEP_0 - 1);
      SPD_1S:    step_last = STEP_W'(STEP_1 - 1);
      SPD_500MS: step_last = STEP_W'(STEP_2 - 1);
      SPD_250MS: step_last = STEP_W'(STEP_3 - 1);
    endcase
  end

  assign step_tick = (step_cnt_q == step_last);

  // A speed change restarts the interval so a faster mode never overruns its limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         step_cnt_q <= '0;
    else if (speed_chg || step_tick) step_cnt_q <= '0;
    else                             step_cnt_q <= step_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RISE;
      bright_q     <= '0;
      color_q      <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      cycle_done_q <= 1'b0;
      if (step_tick) begin
        unique case (state_q)
          RISE: begin
            bright_q <= bright_q + 8'd1;
            if (bright_q + 8'd1 == MAX_B) state_q <= FALL;
          end
          FALL: begin
            bright_q <= bright_q - 8'd1;
            if (bright_q == 8'd1) begin
              state_q      <= RISE;
              color_q      <= (color_q == LAST_C) ? 3'd0 : color_q + 3'd1;
              cycle_done_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.speed_mode = speed_q;
  assign bus.led_mode   = 4'b0001 << speed_q;
  assign bus.brightness = bright_q;
  assign bus.color_idx  = color_q;
  assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_breath_sequencer.sv
// Scoreboard bench: 1 ms = 8 clk, MAX_BRIGHT 100, giving steps of 80/40/20/10 clk.
module tb_breath_sequencer;

  localparam int MS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  breath_sequencer_if bif ();

  breath_sequencer #(
    .CLK_FREQ    (8000),
    .DEBOUNCE_MS (4),
    .MAX_BRIGHT  (100),
    .NUM_COLORS  (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_chg = 0;
  bit         strict = 1'b0;
  logic [1:0] prev_speed = 2'd0;
  logic [7:0] prev_b = 8'd0;
  logic [1:0] exp_speed [$];
  logic [2:0] exp_color [$];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void miss(string name, int act);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected none", name, act);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT changes speed or completes a breath.
  always @(negedge clk) begin
    if (bif.brightness != prev_b) last_chg <= cyc;
    prev_b <= bif.brightness;
    if (rst) begin
      prev_speed <= bif.speed_mode;
    end else begin
      if (bif.speed_mode != prev_speed) begin
        if (exp_speed.size() == 0) begin
          miss("speed_unexpected", int'(bif.speed_mode));
        end else begin
          chk("speed_mode", int'(bif.speed_mode), int'(exp_speed[0]));
          chk("led_mode", int'(bif.led_mode), 1 << exp_speed[0]);
          void'(exp_speed.pop_front());
        end
        prev_speed <= bif.speed_mode;
      end
      if (bif.cycle_done) begin
        chk("cycle_bright", int'(bif.brightness), 0);
        if (exp_color.size() != 0) begin
          chk("color_idx", int'(bif.color_idx), int'(exp_color[0]));
          void'(exp_color.pop_front());
        end else if (strict) begin
          miss("cycle_unexpected", int'(bif.color_idx));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [1:0] b, input int ms);
    @(negedge clk);
    bif.btn = b;
    repeat (ms * MS) @(negedge clk);
    bif.btn = 2'b00;
    repeat (10 * MS) @(negedge clk);
  endtask

  task automatic wait_change(input int budget, output int t);
    logic [7:0] b0;
    int n;
    b0 = bif.brightness;
    n = 0;
    while (bif.brightness == b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bif.brightness == b0) miss("bright_change_timeout", int'(b0));
    t = cyc;
  endtask

  task automatic drain_colors(input int budget);
    int n;
    n = 0;
    while (exp_color.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("color_queue_left", exp_color.size(), 0);
  endtask

  initial begin
    int t0, t1, c0;
    logic [7:0] pb;
    bif.btn = 2'b00;

    // Reset state and a full breath at the slowest speed.
    #3;
    chk("rst_speed", int'(bif.speed_mode), 0);
    chk("rst_led", int'(bif.led_mode), 1);
    chk("rst_bright", int'(bif.brightness), 0);
    chk("rst_color", int'(bif.color_idx), 0);
    chk("rst_cycle", int'(bif.cycle_done), 0);
    exp_color.push_back(3'd1);
    strict = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick(79);
    chk("bright_before_step", int'(bif.brightness), 0);
    tick(1);
    chk("bright_first_step", int'(bif.brightness), 1);
    tick(8000 - 80);
    chk("bright_peak", int'(bif.brightness), 100);
    tick(79);
    chk("bright_peak_hold", int'(bif.brightness), 100);
    tick(1);
    chk("bright_after_peak", int'(bif.brightness), 99);
    tick(16000 - 8080);
    chk("bright_end", int'(bif.brightness), 0);
    chk("cycle_done_pulse", int'(bif.cycle_done), 1);
    chk("color_after_breath", int'(bif.color_idx), 1);
    tick(1);
    chk("cycle_done_clear", int'(bif.cycle_done), 0);
    strict = 1'b0;

    // One faster press, then a short glitch that must be ignored.
    exp_speed.push_back(2'd1);
    press(2'b01, 10);
    chk("speed_after_press", int'(bif.speed_mode), 1);
    wait_change(200, t0);
    wait_change(200, t1);
    chk("step_len_speed1", t1 - t0, 40);
    press(2'b01, 2);
    chk("speed_after_glitch", int'(bif.speed_mode), 1);

    // Saturation both ways.
    exp_speed.push_back(2'd2);
    exp_speed.push_back(2'd3);
    repeat (4) press(2'b01, 10);
    chk("speed_sat_hi", int'(bif.speed_mode), 3);
    chk("led_sat_hi", int'(bif.led_mode), 8);
    exp_speed.push_back(2'd2);
    exp_speed.push_back(2'd1);
    exp_speed.push_back(2'd0);
    repeat (5) press(2'b10, 10);
    chk("speed_sat_lo", int'(bif.speed_mode), 0);
    chk("led_sat_lo", int'(bif.led_mode), 1);

    // Simultaneous presses: no speed change and the step phase is kept.
    @(negedge clk);
    c0 = cyc;
    exp_speed.push_back(2'd1);
    press(2'b01, 10);
    t0 = last_chg;
    while (cyc < c0 + 168) @(negedge clk);
    press(2'b11, 10);
    wait_change(200, t1);
    chk("both_speed", int'(bif.speed_mode), 1);
    chk("both_step_phase", (t1 - t0) % 40, 0);
    chk("speed_queue_left", exp_speed.size(), 0);

    // Seven breaths at the fastest speed.
    do_reset();
    exp_speed.push_back(2'd1);
    exp_speed.push_back(2'd2);
    exp_speed.push_back(2'd3);
    for (int i = 1; i <= 7; i++) exp_color.push_back(3'(i % 7));
    strict = 1'b1;
    repeat (3) press(2'b01, 10);
    chk("speed_fast", int'(bif.speed_mode), 3);
    drain_colors(16000);
    tick(1000);
    strict = 1'b0;

    // Asynchronous reset in the middle of a falling ramp.
    do_reset();
    exp_speed.push_back(2'd1);
    exp_speed.push_back(2'd2);
    for (int i = 1; i <= 4; i++) exp_color.push_back(3'(i));
    strict = 1'b1;
    repeat (2) press(2'b01, 10);
    drain_colors(18000);
    strict = 1'b0;
    pb = bif.brightness;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (pb == 8'd58 && bif.brightness == 8'd57) break;
      pb = bif.brightness;
    end
    chk("fall_57_found", int'(bif.brightness), 57);
    chk("fall_57_color", int'(bif.color_idx), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_speed", int'(bif.speed_mode), 0);
    chk("arst_led", int'(bif.led_mode), 1);
    chk("arst_bright", int'(bif.brightness), 0);
    chk("arst_color", int'(bif.color_idx), 0);
    chk("arst_cycle", int'(bif.cycle_done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick(79);
    chk("restart_before_step", int'(bif.brightness), 0);
    tick(1);
    chk("restart_first_step", int'(bif.brightness), 1);
    tick(80);
    chk("restart_rising", int'(bif.brightness), 2);
    chk("final_speed_queue", exp_speed.size(), 0);
    chk("final_color_queue", exp_color.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
